mod_dac_stream: RTL and testbench

Parametrised successor to the fixed stereo DAC path of the audio driver. It buffers multi-channel PCM frames in a small FIFO and serialises them onto the codec DAC data line, generating LRCK/frame-sync from the codec-supplied bit clock. Supports I2S and left-justified framing, 1–8 channels (TDM when more than 2), and configurable sample and slot widths, with underrun detection. It sits between the sample source and the codec pins, beside the I2C configuration logic inside the audio driver.

---
 rtl/mod_dac_stream.sv | 126 ++++++++++++
 tb/tb_mod_dac_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_dac_stream.sv
// Multi-channel PCM to serial DAC stream: frame FIFO, bclk-driven serialiser,
// I2S / left-justified / TDM framing and underrun accounting.
module mod_dac_stream #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_bclk,
  input  logic [CHANNELS*SAMPLE_W-1:0]  i_sample,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_dacdat,
  output logic                          o_lrck,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic [7:0]                    o_underrun_count
);

  localparam int FW    = CHANNELS * SAMPLE_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NSLOT = (CHANNELS == 1) ? 2 : CHANNELS;
  localparam int BW    = $clog2(SLOT_W);
  localparam int SW    = $clog2(NSLOT);
  localparam logic [BW-1:0] B_LAST = BW'(SLOT_W - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NSLOT - 1);

  logic          bclk_s1, bclk_s2, bclk_d, fall;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          rst_q, full, empty, push, pop, boundary;
  logic [BW-1:0] bit_idx;
  logic [SW-1:0] slot_idx;
  logic [FW-1:0] frame_q, cur_frame, shifted;
  logic          cur_bit, cur_lrck;
  int            k, ch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_d  <= 1'b0;
    end else begin
      bclk_s1 <= i_bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
    end
  end

  assign fall     = bclk_d & ~bclk_s2;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  // rst_q holds o_ready low for the first cycle out of reset
  assign o_ready  = !full && !rst_q;
  assign push     = i_valid && o_ready;
  assign boundary = (bit_idx == '0) && (slot_idx == '0);
  assign pop      = fall && boundary && !empty;
  assign o_level  = wr_ptr - rd_ptr;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_sample;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // At a frame boundary the bit is taken from the frame being loaded, so the
  // left-justified MSB can appear at b=0.
  always_comb begin
    cur_frame = frame_q;
    if (boundary) cur_frame = empty ? '0 : mem[rd_ptr[AW-1:0]];
    k       = int'(bit_idx) - ((MODE == 0) ? 1 : 0);
    ch      = (CHANNELS == 1) ? 0 : int'(slot_idx);
    shifted = '0;
    cur_bit = 1'b0;
    if (k >= 0 && k < SAMPLE_W) begin
      shifted = cur_frame >> (ch * SAMPLE_W + SAMPLE_W - 1 - k);
      cur_bit = shifted[0];
    end
    cur_lrck = (CHANNELS <= 2) ? (slot_idx == S_LAST) : boundary;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_q            <= 1'b1;
      bit_idx          <= '0;
      slot_idx         <= '0;
      frame_q          <= '0;
      o_dacdat         <= 1'b0;
      o_lrck           <= 1'b0;
      o_underrun       <= 1'b0;
      o_underrun_count <= 8'd0;
    end else begin
      rst_q      <= 1'b0;
      o_underrun <= 1'b0;
      if (fall) begin
        o_dacdat <= cur_bit;
        o_lrck   <= cur_lrck;
        if (boundary) begin
          frame_q <= cur_frame;
          if (empty) begin
            o_underrun <= 1'b1;
            if (o_underrun_count != 8'hFF) o_underrun_count <= o_underrun_count + 8'd1;
          end
        end
        if (bit_idx == B_LAST) begin
          bit_idx  <= '0;
          slot_idx <= (slot_idx == S_LAST) ? '0 : slot_idx + 1'b1;
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_dac_stream.sv
// Scoreboard bench for mod_dac_stream: four configurations (LJ stereo, I2S stereo,
// TDM 4ch, mono I2S), each with its own bclk driven from the test tasks.
module tb_mod_dac_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic bclk_lj = 1'b1, bclk_i2s = 1'b1, bclk_tdm = 1'b1, bclk_mono = 1'b1;
  logic valid_lj = 1'b0, valid_i2s = 1'b0, valid_tdm = 1'b0, valid_mono = 1'b0;
  logic [31:0] smp_st = '0;
  logic [95:0] smp_tdm = '0;
  logic [7:0]  smp_mono = '0;

  logic rdy_lj, dat_lj, lr_lj, unr_lj;       logic [2:0] lvl_lj;   logic [7:0] cnt_lj;
  logic rdy_i2s, dat_i2s, lr_i2s, unr_i2s;   logic [2:0] lvl_i2s;  logic [7:0] cnt_i2s;
  logic rdy_tdm, dat_tdm, lr_tdm, unr_tdm;   logic [2:0] lvl_tdm;  logic [7:0] cnt_tdm;
  logic rdy_mono, dat_mono, lr_mono, unr_mono; logic [1:0] lvl_mono; logic [7:0] cnt_mono;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  mod_dac_stream #(.SAMPLE_W(16), .SLOT_W(32), .CHANNELS(2), .FIFO_DEPTH(4), .MODE(1)) dut_lj (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk_lj), .i_sample(smp_st), .i_valid(valid_lj),
    .o_ready(rdy_lj), .o_dacdat(dat_lj), .o_lrck(lr_lj), .o_level(lvl_lj),
    .o_underrun(unr_lj), .o_underrun_count(cnt_lj));

  mod_dac_stream #(.SAMPLE_W(16), .SLOT_W(32), .CHANNELS(2), .FIFO_DEPTH(4), .MODE(0)) dut_i2s (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk_i2s), .i_sample(smp_st), .i_valid(valid_i2s),
    .o_ready(rdy_i2s), .o_dacdat(dat_i2s), .o_lrck(lr_i2s), .o_level(lvl_i2s),
    .o_underrun(unr_i2s), .o_underrun_count(cnt_i2s));

  mod_dac_stream #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .FIFO_DEPTH(4), .MODE(0)) dut_tdm (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk_tdm), .i_sample(smp_tdm), .i_valid(valid_tdm),
    .o_ready(rdy_tdm), .o_dacdat(dat_tdm), .o_lrck(lr_tdm), .o_level(lvl_tdm),
    .o_underrun(unr_tdm), .o_underrun_count(cnt_tdm));

  mod_dac_stream #(.SAMPLE_W(8), .SLOT_W(9), .CHANNELS(1), .FIFO_DEPTH(2), .MODE(0)) dut_mono (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk_mono), .i_sample(smp_mono), .i_valid(valid_mono),
    .o_ready(rdy_mono), .o_dacdat(dat_mono), .o_lrck(lr_mono), .o_level(lvl_mono),
    .o_underrun(unr_mono), .o_underrun_count(cnt_mono));

  // Expected {lrck, dat} per bclk for one whole frame, derived from the framing rules.
  task automatic push_expect(input int mode, input int nch, input int sw, input int slw,
                             input logic [95:0] frame);
    int nslots;
    int k;
    logic [95:0] tmp;
    logic d, lr;
    nslots = (nch == 1) ? 2 : nch;
    for (int s = 0; s < nslots; s++) begin
      for (int b = 0; b < slw; b++) begin
        k = (mode == 0) ? b - 1 : b;
        d = 1'b0;
        if (k >= 0 && k < sw) begin
          tmp = frame >> (((nch == 1) ? 0 : s) * sw + sw - 1 - k);
          d = tmp[0];
        end
        lr = (nch <= 2) ? (s == 1) : (b == 0 && s == 0);
        exp_q.push_back({lr, d});
      end
    end
  endtask

  task automatic set_bclk(input int which, input logic v);
    case (which)
      0: bclk_lj = v;
      1: bclk_i2s = v;
      2: bclk_tdm = v;
      default: bclk_mono = v;
    endcase
  endtask

  // One bclk period (8 clk); outputs captured 3 clk after the falling edge.
  task automatic bclk_step(input int which, output logic lr, output logic d, output logic u);
    set_bclk(which, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    case (which)
      0: begin lr = lr_lj;   d = dat_lj;   u = unr_lj;   end
      1: begin lr = lr_i2s;  d = dat_i2s;  u = unr_i2s;  end
      2: begin lr = lr_tdm;  d = dat_tdm;  u = unr_tdm;  end
      default: begin lr = lr_mono; d = dat_mono; u = unr_mono; end
    endcase
    @(posedge clk);
    #1;
    set_bclk(which, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int which, input logic [95:0] frame, output logic acc);
    case (which)
      0: begin smp_st = frame[31:0]; valid_lj = 1'b1; acc = rdy_lj; end
      1: begin smp_st = frame[31:0]; valid_i2s = 1'b1; acc = rdy_i2s; end
      2: begin smp_tdm = frame; valid_tdm = 1'b1; acc = rdy_tdm; end
      default: begin smp_mono = frame[7:0]; valid_mono = 1'b1; acc = rdy_mono; end
    endcase
    @(posedge clk);
    #1;
    valid_lj = 1'b0; valid_i2s = 1'b0; valid_tdm = 1'b0; valid_mono = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dat_lj, lr_lj, unr_lj} !== 3'b000) begin failures++; $display("[TB] FAIL reset_outs: got %b expected 000", {dat_lj, lr_lj, unr_lj}); end
    checks++; if (lvl_lj !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", lvl_lj); end
    checks++; if (cnt_lj !== 8'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", cnt_lj); end
    checks++; if ({rdy_lj, rdy_i2s, rdy_tdm, rdy_mono} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0000", {rdy_lj, rdy_i2s, rdy_tdm, rdy_mono}); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({rdy_lj, rdy_i2s, rdy_tdm, rdy_mono} !== 4'b1111) begin failures++; $display("[TB] FAIL ready_release: got %b expected 1111", {rdy_lj, rdy_i2s, rdy_tdm, rdy_mono}); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_left_justified();
    logic acc, lr, d, u;
    logic [1:0] e;
    exp_q.delete();
    push_frame(0, {64'd0, 16'h8001, 16'hA5F0}, acc);
    push_expect(1, 2, 16, 32, {64'd0, 16'h8001, 16'hA5F0});
    push_frame(0, {64'd0, 16'h1234, 16'hFEDC}, acc);
    push_expect(1, 2, 16, 32, {64'd0, 16'h1234, 16'hFEDC});
    checks++; if (lvl_lj !== 3'd2) begin failures++; $display("[TB] FAIL lj_level: got %0d expected 2", lvl_lj); end
    for (int i = 0; i < 128; i++) begin
      bclk_step(0, lr, d, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL lj_stream step %0d: got {lrck,dat}=%b expected %b", i, {lr, d}, e); end
    end
  endtask

  task automatic test_backpressure();
    logic acc, lr, d, u;
    logic [1:0] e;
    int acc_n;
    acc_n = 0;
    exp_q.delete();
    valid_lj = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp_st = 32'h1357_0000 + 32'(i * 17);
      acc = rdy_lj;
      @(posedge clk);
      #1;
      if (acc) begin
        push_expect(1, 2, 16, 32, {64'd0, 32'h1357_0000 + 32'(i * 17)});
        acc_n++;
      end
    end
    checks++; if (acc_n != 4) begin failures++; $display("[TB] FAIL bp_accepted: got %0d expected 4", acc_n); end
    checks++; if ({rdy_lj, lvl_lj} !== {1'b0, 3'd4}) begin failures++; $display("[TB] FAIL bp_full: got ready=%b level=%0d expected ready=0 level=4", rdy_lj, lvl_lj); end
    smp_st = 32'hC3C3_5A5A;
    bclk_step(0, lr, d, u);
    valid_lj = 1'b0;
    push_expect(1, 2, 16, 32, {64'd0, 32'hC3C3_5A5A});
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    checks++; if ({lr, d} !== e) begin failures++; $display("[TB] FAIL bp_stream step 0: got %b expected %b", {lr, d}, e); end
    checks++; if ({rdy_lj, lvl_lj} !== {1'b0, 3'd4}) begin failures++; $display("[TB] FAIL bp_refill: got ready=%b level=%0d expected ready=0 level=4", rdy_lj, lvl_lj); end
    for (int i = 1; i < 5 * 64; i++) begin
      bclk_step(0, lr, d, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL bp_stream step %0d: got %b expected %b", i, {lr, d}, e); end
    end
  endtask

  task automatic test_i2s();
    logic acc, lr, d, u;
    logic [1:0] e;
    exp_q.delete();
    push_frame(1, {64'd0, 16'h8001, 16'hA5F0}, acc);
    push_expect(0, 2, 16, 32, {64'd0, 16'h8001, 16'hA5F0});
    push_frame(1, {64'd0, 16'h7FFE, 16'h0001}, acc);
    push_expect(0, 2, 16, 32, {64'd0, 16'h7FFE, 16'h0001});
    for (int i = 0; i < 128; i++) begin
      bclk_step(1, lr, d, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL i2s_stream step %0d: got %b expected %b", i, {lr, d}, e); end
    end
  endtask

  task automatic test_underrun();
    logic acc, lr, d, u;
    logic [1:0] e;
    int pulses;
    pulses = 0;
    exp_q.delete();
    push_frame(1, {64'd0, 32'h0F0F_7E81}, acc);
    push_expect(0, 2, 16, 32, {64'd0, 32'h0F0F_7E81});
    for (int f = 0; f < 3; f++) push_expect(0, 2, 16, 32, 96'd0);
    for (int i = 0; i < 4 * 64; i++) begin
      bclk_step(1, lr, d, u);
      if (u) pulses++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL underrun_stream step %0d: got %b expected %b", i, {lr, d}, e); end
    end
    checks++; if (pulses != 3) begin failures++; $display("[TB] FAIL underrun_pulses: got %0d expected 3", pulses); end
    checks++; if (cnt_i2s !== 8'd3) begin failures++; $display("[TB] FAIL underrun_count: got %0d expected 3", cnt_i2s); end
  endtask

  task automatic test_tdm();
    logic acc, lr, d, u;
    logic [1:0] e;
    int syncs;
    syncs = 0;
    exp_q.delete();
    push_frame(2, {24'h000004, 24'h000003, 24'h000002, 24'h000001}, acc);
    push_expect(0, 4, 24, 32, {24'h000004, 24'h000003, 24'h000002, 24'h000001});
    push_frame(2, {24'h7FFFFF, 24'h123456, 24'h800000, 24'hABCDEF}, acc);
    push_expect(0, 4, 24, 32, {24'h7FFFFF, 24'h123456, 24'h800000, 24'hABCDEF});
    for (int i = 0; i < 256; i++) begin
      bclk_step(2, lr, d, u);
      if (lr) syncs++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL tdm_stream step %0d: got %b expected %b", i, {lr, d}, e); end
    end
    checks++; if (syncs != 2) begin failures++; $display("[TB] FAIL tdm_syncs: got %0d expected 2", syncs); end
  endtask

  task automatic test_mono_saturate();
    logic acc, lr, d, u;
    logic [1:0] e;
    int pulses;
    pulses = 0;
    exp_q.delete();
    push_frame(3, 96'hA5, acc);
    push_expect(0, 1, 8, 9, 96'hA5);
    for (int f = 0; f < 256; f++) push_expect(0, 1, 8, 9, 96'd0);
    for (int i = 0; i < 257 * 18; i++) begin
      bclk_step(3, lr, d, u);
      if (u) pulses++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL mono_stream step %0d: got %b expected %b", i, {lr, d}, e); end
      if (i == 256 * 18 - 1) begin
        checks++; if (cnt_mono !== 8'd255) begin failures++; $display("[TB] FAIL sat_count_255: got %0d expected 255", cnt_mono); end
      end
    end
    checks++; if (cnt_mono !== 8'd255) begin failures++; $display("[TB] FAIL sat_count_hold: got %0d expected 255", cnt_mono); end
    checks++; if (pulses != 256) begin failures++; $display("[TB] FAIL sat_pulses: got %0d expected 256", pulses); end
  endtask

  task automatic test_reset_mid_frame();
    logic acc, lr, d, u;
    logic [1:0] e;
    exp_q.delete();
    push_frame(1, {64'd0, 16'hFFFF, 16'h1234}, acc);
    push_expect(0, 2, 16, 32, {64'd0, 16'hFFFF, 16'h1234});
    for (int i = 0; i < 43; i++) begin
      bclk_step(1, lr, d, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL mid_pre step %0d: got %b expected %b", i, {lr, d}, e); end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({dat_i2s, lr_i2s, unr_i2s, rdy_i2s} !== 4'b0000) begin failures++; $display("[TB] FAIL mid_reset_outs: got %b expected 0000", {dat_i2s, lr_i2s, unr_i2s, rdy_i2s}); end
    checks++; if ({lvl_i2s, cnt_i2s} !== 11'd0) begin failures++; $display("[TB] FAIL mid_reset_state: got level=%0d count=%0d expected 0/0", lvl_i2s, cnt_i2s); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
    push_frame(1, {64'd0, 16'h8001, 16'hA5F0}, acc);
    push_expect(0, 2, 16, 32, {64'd0, 16'h8001, 16'hA5F0});
    checks++; if (lvl_i2s !== 3'd1) begin failures++; $display("[TB] FAIL mid_level: got %0d expected 1", lvl_i2s); end
    for (int i = 0; i < 64; i++) begin
      bclk_step(1, lr, d, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if ({lr, d} !== e) begin failures++; $display("[TB] FAIL mid_post step %0d: got %b expected %b", i, {lr, d}, e); end
    end
  endtask

  initial begin
    test_reset();
    test_left_justified();
    test_backpressure();
    test_i2s();
    test_underrun();
    test_tdm();
    test_mono_saturate();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
